// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the FIFO family.
//   fifo_depth(addr_bits)          : number of entries, 2**addr_bits.
//   ptr_full(wp, rp, addr_bits)    : pointers (addr_bits+1 wide, zero-extended
//                                    to 32 bits) describe a full queue: low
//                                    bits equal, wrap bit different.
//   ptr_empty(wp, rp, addr_bits)   : pointers are identical (nothing between).
// -----------------------------------------------------------------------------
package fifo_pkg;

   function automatic int fifo_depth(input int addr_bits);
      return 1 << addr_bits;
   endfunction

   // Bits above the wrap bit are masked so callers may pass zero-extended
   // pointers of any width up to 31 address bits.
   function automatic logic ptr_full(input logic [31:0] wp,
                                     input logic [31:0] rp,
                                     input int          addr_bits);
      logic [31:0] w_mask;
      logic [31:0] w_diff;
      w_mask = (32'd2 << addr_bits) - 32'd1;
      w_diff = (wp ^ rp) & w_mask;
      return w_diff == (32'd1 << addr_bits);
   endfunction

   function automatic logic ptr_empty(input logic [31:0] wp,
                                      input logic [31:0] rp,
                                      input int          addr_bits);
      logic [31:0] w_mask;
      w_mask = (32'd2 << addr_bits) - 32'd1;
      return ((wp ^ rp) & w_mask) == 32'd0;
   endfunction

endpackage

// File: rtl/fifo_fwft_if.sv
// -----------------------------------------------------------------------------
// fifo_fwft_if
// Producer/consumer bundle of the first-word-fall-through FIFO.
//   flush        : synchronous clear of all contents.
//   w_en/w_ready : push request / FIFO can accept; dataW is the push payload.
//   r_en/r_ready : pop request / dataR holds a valid head entry.
//   dataR        : head of queue, visible before it is popped.
//   fifo_size    : occupancy 0..2**AddrBitWidth.
//   almost_full, almost_empty : threshold flags on occupancy.
//   overflow, underflow, clr_err : sticky error flags and their clear, present
//                  only when FIFO_FWFT_ERR_FLAGS_EN is defined.
// Handshake: a transfer happens at a rising clk edge where the request and its
// ready are both 1; a request while ready is 0 is dropped; ready never depends
// combinationally on the request; payload is sampled only on a transfer.
// master = producer/consumer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface fifo_fwft_if #(
   parameter int DataWidth    = 32,
   parameter int AddrBitWidth = 4
);
   logic                  flush;
   logic                  w_en;
   logic                  w_ready;
   logic [DataWidth-1:0]  dataW;
   logic                  r_en;
   logic                  r_ready;
   logic [DataWidth-1:0]  dataR;
   logic [AddrBitWidth:0] fifo_size;
   logic                  almost_full;
   logic                  almost_empty;
`ifdef FIFO_FWFT_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output flush, w_en, dataW, r_en, clr_err,
      input  w_ready, r_ready, dataR, fifo_size, almost_full, almost_empty,
             overflow, underflow
   );
   modport slave (
      input  flush, w_en, dataW, r_en, clr_err,
      output w_ready, r_ready, dataR, fifo_size, almost_full, almost_empty,
             overflow, underflow
   );
`else
   modport master (
      output flush, w_en, dataW, r_en,
      input  w_ready, r_ready, dataR, fifo_size, almost_full, almost_empty
   );
   modport slave (
      input  flush, w_en, dataW, r_en,
      output w_ready, r_ready, dataR, fifo_size, almost_full, almost_empty
   );
`endif
endinterface

// File: rtl/fifo_ram_2p.sv
// -----------------------------------------------------------------------------
// fifo_ram_2p
// Simple dual-port RAM, DataWidth x 2**AddrBitWidth, one write port and one
// registered read port.
//   clk, rst           : clock; rst clears only the read data register.
//   i_we/i_waddr/i_wdata : write port.
//   i_re/i_raddr       : read enable/address; o_rdata updates on the edge
//                        where i_re=1 and holds otherwise.
// -----------------------------------------------------------------------------
module fifo_ram_2p
   import fifo_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddrBitWidth = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_we,
   input  logic [AddrBitWidth-1:0] i_waddr,
   input  logic [DataWidth-1:0]    i_wdata,
   input  logic                    i_re,
   input  logic [AddrBitWidth-1:0] i_raddr,
   output logic [DataWidth-1:0]    o_rdata
);
   localparam int DEPTH = fifo_depth(AddrBitWidth);

   logic [DataWidth-1:0] r_mem [DEPTH];
   logic [DataWidth-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Reset on the read register gives a defined dataR of 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
// Single-clock first-word-fall-through FIFO using all 2**AddrBitWidth entries.
// The head entry lives in an output stage (RAM read register, or a bypass
// register) so it is visible on dataR before it is popped.
//   clk  : rising-edge clock.   rst : asynchronous, active-high reset.
//   bus  : fifo_fwft_if.slave (flush, w_en/w_ready/dataW, r_en/r_ready/dataR,
//          fifo_size, almost_full, almost_empty and, with
//          FIFO_FWFT_ERR_FLAGS_EN defined, overflow/underflow/clr_err).
// Optional feature macro: FIFO_FWFT_ERR_FLAGS_EN (sticky error flags).
// -----------------------------------------------------------------------------
module fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddrBitWidth = 4,
   parameter int AfullThr     = (1 << AddrBitWidth) - 2,
   parameter int AemptyThr    = 1
) (
   input  logic       clk,
   input  logic       rst,
   fifo_fwft_if.slave bus
);
   localparam int PW = AddrBitWidth + 1;
   localparam logic [PW-1:0] AFULL_THR  = PW'(AfullThr);
   localparam logic [PW-1:0] AEMPTY_THR = PW'(AemptyThr);
   localparam logic [PW-1:0] ONE        = PW'(1);

   // Pointers: wr = next RAM slot to write, rd = next RAM slot to prefetch,
   // hd = slot of the entry currently at the head (advances on pop).
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [PW-1:0]        r_hd_ptr;
   logic [PW-1:0]        r_size;
   logic                 r_w_ready;
   logic                 r_r_ready;
   logic                 r_afull;
   logic                 r_aempty;
   logic                 r_byp_sel;
   logic [DataWidth-1:0] r_byp_data;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_ram_has;
   logic                 w_load_ram;
   logic                 w_load_byp;
   logic [PW-1:0]        w_wr_nxt;
   logic [PW-1:0]        w_rd_nxt;
   logic [PW-1:0]        w_hd_nxt;
   logic [PW-1:0]        w_size_nxt;
   logic                 w_r_ready_nxt;
   logic [DataWidth-1:0] w_ram_q;

   always_comb begin
      w_push    = bus.w_en & r_w_ready & ~bus.flush;
      w_pop     = bus.r_en & r_r_ready & ~bus.flush;
      w_ram_has = ~ptr_empty(32'(r_wr_ptr), 32'(r_rd_ptr), AddrBitWidth);

      // Refill the output stage from RAM whenever it is (or is becoming) free.
      w_load_ram = (~r_r_ready | w_pop) & w_ram_has & ~bus.flush;
      // With the RAM empty, a push that coincides with the pop of the last
      // entry goes straight to the output stage, so push+pop at occupancy 1
      // keeps flowing. A push into a completely empty FIFO still takes the
      // RAM path (two-cycle write-to-read latency).
      w_load_byp = w_pop & ~w_ram_has & w_push;

      w_wr_nxt   = r_wr_ptr + (w_push ? ONE : '0);
      w_rd_nxt   = r_rd_ptr + ((w_load_ram | w_load_byp) ? ONE : '0);
      w_hd_nxt   = r_hd_ptr + (w_pop ? ONE : '0);
      w_size_nxt = r_size;
      if (w_push && !w_pop) begin
         w_size_nxt = r_size + ONE;
      end else if (w_pop && !w_push) begin
         w_size_nxt = r_size - ONE;
      end

      w_r_ready_nxt = r_r_ready;
      if (w_load_ram || w_load_byp) begin
         w_r_ready_nxt = 1'b1;
      end else if (w_pop) begin
         w_r_ready_nxt = 1'b0;
      end

      if (bus.flush) begin
         w_wr_nxt      = '0;
         w_rd_nxt      = '0;
         w_hd_nxt      = '0;
         w_size_nxt    = '0;
         w_r_ready_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_hd_ptr   <= '0;
         r_size     <= '0;
         r_w_ready  <= 1'b0;
         r_r_ready  <= 1'b0;
         r_afull    <= 1'b0;
         r_aempty   <= 1'b1;
         r_byp_sel  <= 1'b0;
         r_byp_data <= '0;
      end else begin
         r_wr_ptr  <= w_wr_nxt;
         r_rd_ptr  <= w_rd_nxt;
         r_hd_ptr  <= w_hd_nxt;
         r_size    <= w_size_nxt;
         r_w_ready <= ~ptr_full(32'(w_wr_nxt), 32'(w_hd_nxt), AddrBitWidth);
         r_r_ready <= w_r_ready_nxt;
         r_afull   <= (w_size_nxt >= AFULL_THR);
         r_aempty  <= (w_size_nxt <= AEMPTY_THR);
         // Output select only changes on a load, so dataR holds when empty.
         if (w_load_byp) begin
            r_byp_sel  <= 1'b1;
            r_byp_data <= bus.dataW;
         end else if (w_load_ram) begin
            r_byp_sel  <= 1'b0;
         end
      end
   end

   fifo_ram_2p #(
      .DataWidth    (DataWidth),
      .AddrBitWidth (AddrBitWidth)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AddrBitWidth-1:0]),
      .i_wdata (bus.dataW),
      .i_re    (w_load_ram),
      .i_raddr (r_rd_ptr[AddrBitWidth-1:0]),
      .o_rdata (w_ram_q)
   );

   assign bus.dataR        = r_byp_sel ? r_byp_data : w_ram_q;
   assign bus.w_ready      = r_w_ready;
   assign bus.r_ready      = r_r_ready;
   assign bus.fifo_size    = r_size;
   assign bus.almost_full  = r_afull;
   assign bus.almost_empty = r_aempty;

`ifdef FIFO_FWFT_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky; clr_err wins over a new error in the same cycle; flush leaves them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.clr_err) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.w_en && !r_w_ready) begin
            r_overflow <= 1'b1;
         end
         if (bus.r_en && !r_r_ready) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_fifo_fwft
// Self-checking bench for fifo_fwft (DataWidth=32, AddrBitWidth=4). Directed
// table of vectors, hand-written corner sequences, then random traffic checked
// against a queue-based reference model. Honours FIFO_FWFT_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_fifo_fwft;
   localparam int DW     = 32;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int AFULL  = 14;
   localparam int AEMPTY = 1;

   logic clk;
   logic rst;

   fifo_fwft_if #(.DataWidth(DW), .AddrBitWidth(AW)) bus ();

   fifo_fwft #(
      .DataWidth    (DW),
      .AddrBitWidth (AW),
      .AfullThr     (AFULL),
      .AemptyThr    (AEMPTY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / reference model ----------------
   int            n_checks;
   int            n_err;
   logic [DW-1:0] exp_q[$];
   logic          m_w_ready;
   logic          m_r_ready;
   logic          m_ovf;
   logic          m_unf;
   logic [DW-1:0] m_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_w_ready = 1'b0;
      m_r_ready = 1'b0;
      m_last    = '0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
   endtask

   // One clock edge of the queue abstraction. An entry pushed into an empty
   // FIFO becomes visible one edge later; otherwise the head is always shown.
   task automatic model_edge(input logic fl, input logic we, input logic [DW-1:0] d,
                             input logic re, input logic ce);
      int   prev_cnt;
      logic w_acc;
      logic r_acc;
      w_acc = we && m_w_ready;
      r_acc = re && m_r_ready;
      if (ce) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (we && !m_w_ready) m_ovf = 1'b1;
         if (re && !m_r_ready) m_unf = 1'b1;
      end
      prev_cnt = exp_q.size();
      if (fl) begin
         exp_q.delete();
      end else begin
         if (r_acc) void'(exp_q.pop_front());
         if (w_acc) exp_q.push_back(d);
      end
      m_w_ready = exp_q.size() < DEPTH;
      m_r_ready = (exp_q.size() > 0) && (prev_cnt > 0);
      if (m_r_ready) m_last = exp_q[0];
   endtask

   task automatic check_model();
      int cnt;
      cnt = exp_q.size();
      check("size",         32'(bus.fifo_size),    32'(cnt));
      check("r_ready",      32'(bus.r_ready),      32'(m_r_ready));
      check("w_ready",      32'(bus.w_ready),      32'(m_w_ready));
      check("dataR",        bus.dataR,             m_last);
      check("almost_full",  32'(bus.almost_full),  32'(cnt >= AFULL));
      check("almost_empty", 32'(bus.almost_empty), 32'(cnt <= AEMPTY));
`ifdef FIFO_FWFT_ERR_FLAGS_EN
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
`endif
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input logic fl, input logic we, input logic [DW-1:0] d,
                        input logic re, input logic ce, input bit chk);
      bus.flush = fl;
      bus.w_en  = we;
      bus.dataW = d;
      bus.r_en  = re;
`ifdef FIFO_FWFT_ERR_FLAGS_EN
      bus.clr_err = ce;
`endif
      @(posedge clk);
      model_edge(fl, we, d, re, ce);
      #1;
      if (chk) check_model();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " size"},         32'(bus.fifo_size),    32'd0);
      check({tag, " r_ready"},      32'(bus.r_ready),      32'd0);
      check({tag, " w_ready"},      32'(bus.w_ready),      32'd0);
      check({tag, " dataR"},        bus.dataR,             32'd0);
      check({tag, " almost_full"},  32'(bus.almost_full),  32'd0);
      check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
`ifdef FIFO_FWFT_ERR_FLAGS_EN
      check({tag, " overflow"},     32'(bus.overflow),     32'd0);
      check({tag, " underflow"},    32'(bus.underflow),    32'd0);
`endif
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          fl;
      logic          we;
      logic [DW-1:0] d;
      logic          re;
      logic [AW:0]   size;
      logic          rr;
      logic          wr;
      logic [DW-1:0] dr;
      logic          af;
      logic          ae;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic fl, input logic we, input logic [DW-1:0] d,
                               input logic re, input int sz, input logic rr,
                               input logic wr, input logic [DW-1:0] dr,
                               input logic af, input logic ae);
      vec_t v;
      v.fl = fl; v.we = we; v.d = d; v.re = re;
      v.size = sz[AW:0]; v.rr = rr; v.wr = wr; v.dr = dr; v.af = af; v.ae = ae;
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0;
      n_err    = 0;
      rst      = 1'b1;
      bus.flush = 1'b0; bus.w_en = 1'b0; bus.dataW = '0; bus.r_en = 1'b0;
`ifdef FIFO_FWFT_ERR_FLAGS_EN
      bus.clr_err = 1'b0;
`endif
      model_reset();

      //            fl we  data  re size rr wr dataR af ae
      tbl[0]  = mk(0, 0, 32'h00, 0, 0, 0, 1, 32'h00, 0, 1); // w_ready rises
      tbl[1]  = mk(0, 1, 32'hA5, 0, 1, 0, 1, 32'h00, 0, 1); // size 1, not yet visible
      tbl[2]  = mk(0, 0, 32'h00, 0, 1, 1, 1, 32'hA5, 0, 1); // visible after 2 edges
      tbl[3]  = mk(0, 1, 32'h3C, 0, 2, 1, 1, 32'hA5, 0, 0);
      tbl[4]  = mk(0, 1, 32'h77, 1, 2, 1, 1, 32'h3C, 0, 0); // push+pop
      tbl[5]  = mk(0, 0, 32'h00, 1, 1, 1, 1, 32'h77, 0, 1);
      tbl[6]  = mk(0, 0, 32'h00, 1, 0, 0, 1, 32'h77, 0, 1); // empty, dataR holds
      tbl[7]  = mk(0, 0, 32'h00, 1, 0, 0, 1, 32'h77, 0, 1); // pop on empty ignored
      tbl[8]  = mk(0, 1, 32'h11, 1, 1, 0, 1, 32'h77, 0, 1);
      tbl[9]  = mk(0, 1, 32'h22, 1, 2, 1, 1, 32'h11, 0, 0); // r_en while not ready
      tbl[10] = mk(0, 1, 32'h33, 1, 2, 1, 1, 32'h22, 0, 0);
      tbl[11] = mk(1, 1, 32'h44, 0, 0, 0, 1, 32'h22, 0, 1); // flush beats w_en
      tbl[12] = mk(0, 0, 32'h00, 0, 0, 0, 1, 32'h22, 0, 1); // 0x44 not stored
      tbl[13] = mk(0, 1, 32'h55, 0, 1, 0, 1, 32'h22, 0, 1);
      tbl[14] = mk(0, 0, 32'h00, 0, 1, 1, 1, 32'h55, 0, 1);
      tbl[15] = mk(0, 1, 32'h66, 1, 1, 1, 1, 32'h66, 0, 1); // push+pop at occupancy 1
      tbl[16] = mk(0, 1, 32'h67, 1, 1, 1, 1, 32'h67, 0, 1);
      tbl[17] = mk(0, 0, 32'h00, 1, 0, 0, 1, 32'h67, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].fl, tbl[i].we, tbl[i].d, tbl[i].re, 1'b0, 1'b0);
         check($sformatf("vec%0d size", i),    32'(bus.fifo_size),    32'(tbl[i].size));
         check($sformatf("vec%0d r_ready", i), 32'(bus.r_ready),      32'(tbl[i].rr));
         check($sformatf("vec%0d w_ready", i), 32'(bus.w_ready),      32'(tbl[i].wr));
         check($sformatf("vec%0d dataR", i),   bus.dataR,             tbl[i].dr);
         check($sformatf("vec%0d afull", i),   32'(bus.almost_full),  32'(tbl[i].af));
         check($sformatf("vec%0d aempty", i),  32'(bus.almost_empty), 32'(tbl[i].ae));
      end

`ifdef FIFO_FWFT_ERR_FLAGS_EN
      check("tbl underflow", 32'(bus.underflow), 32'd1);
      check("tbl overflow",  32'(bus.overflow),  32'd0);
      cycle(0, 0, 0, 0, 1, 1);
      check("clr underflow", 32'(bus.underflow), 32'd0);
      cycle(0, 0, 0, 1, 1, 1);   // clr_err wins over pop on empty
      check("clr+pop underflow", 32'(bus.underflow), 32'd0);
      cycle(0, 0, 0, 1, 0, 1);
      check("pop empty underflow", 32'(bus.underflow), 32'd1);
      cycle(0, 0, 0, 0, 1, 1);
`endif

      // Fill to DEPTH, push once more while full, then drain in order.
      for (int k = 0; k < DEPTH; k++) cycle(0, 1, 32'(k), 0, 0, 1);
      check("full size",    32'(bus.fifo_size),   32'(DEPTH));
      check("full w_ready", 32'(bus.w_ready),     32'd0);
      check("full afull",   32'(bus.almost_full), 32'd1);
      cycle(0, 1, 32'hDEAD, 0, 0, 1);
      check("17th size", 32'(bus.fifo_size), 32'(DEPTH));
`ifdef FIFO_FWFT_ERR_FLAGS_EN
      check("17th overflow", 32'(bus.overflow), 32'd1);
`endif
      check("drain 0", bus.dataR, 32'd0);
      cycle(0, 1, 32'hBEEF, 1, 0, 1);  // push ignored while full, pop taken
      check("full push+pop size", 32'(bus.fifo_size), 32'(DEPTH - 1));
      for (int k = 1; k < DEPTH; k++) begin
         check($sformatf("drain %0d", k), bus.dataR, 32'(k));
         cycle(0, 0, 0, 1, 0, 1);
      end
      check("drained size", 32'(bus.fifo_size), 32'd0);
      cycle(0, 0, 0, 0, 1, 1);

      // Sustained push+pop at occupancy 5 for 40 cycles (pointers wrap twice).
      for (int k = 0; k < 5; k++) cycle(0, 1, 32'(100 + k), 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      for (int j = 0; j < 40; j++) begin
         check($sformatf("stream %0d", j), bus.dataR, (j < 5) ? 32'(100 + j) : 32'(200 + j - 5));
         cycle(0, 1, 32'(200 + j), 1, 0, 1);
      end
      check("stream size", 32'(bus.fifo_size), 32'd5);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 0, 1);

      // Flush with w_en at occupancy 7.
      for (int k = 0; k < 7; k++) cycle(0, 1, 32'(300 + k), 0, 0, 1);
      cycle(1, 1, 32'h4444, 0, 0, 1);
      check("flush size",    32'(bus.fifo_size), 32'd0);
      check("flush r_ready", 32'(bus.r_ready),   32'd0);
      check("flush w_ready", 32'(bus.w_ready),   32'd1);
      cycle(0, 0, 0, 0, 0, 1);
      check("flush not stored", 32'(bus.fifo_size), 32'd0);

      // Asynchronous reset between edges in the middle of a burst.
      for (int k = 0; k < 4; k++) cycle(0, 1, 32'(400 + k), (k > 1), 0, 1);
      bus.w_en = 1'b1;
      #2 rst = 1'b1;
      #1 check_reset_values("async rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 0, 0, 0, 0, 1);
      check("post-rst w_ready", 32'(bus.w_ready), 32'd1);
      cycle(0, 1, 32'h5A5A, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      check("post-rst dataR", bus.dataR, 32'h5A5A);
      cycle(0, 0, 0, 1, 0, 1);

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = (i < 300) ? 70 : 35;
         cycle($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < wp,
               $urandom(),
               $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 4,
               1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/fifo_fwft.md
# fifo_fwft

Parametrised synchronous first-word-fall-through FIFO, the successor to the team's basic single-clock FIFO. It uses the full 2^AddrBitWidth entries, where the previous generation used 2^AddrBitWidth−1. It adds a registered read stage, programmable almost-full/almost-empty flags, a synchronous flush and optional sticky error flags. It sits between producer/consumer stages on the same clock, which use ready/enable handshakes.

## Interface
- DataWidth, 32, payload width in bits.
- AddrBitWidth, 4, log2 of depth; DEPTH = 2^AddrBitWidth entries.
- AfullThr, 2^AddrBitWidth−2, almost_full asserted when occupancy ≥ AfullThr.
- AemptyThr, 1, almost_empty asserted when occupancy ≤ AemptyThr.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- w_en  in  1  push request.
- w_ready  out  1  FIFO can accept a push.
- dataW  in  DataWidth  push data.
- r_en  in  1  pop request; acknowledges the current dataR.
- r_ready  out  1  dataR holds valid head entry.
- dataR  out  DataWidth  head-of-queue data (FWFT).
- fifo_size  out  AddrBitWidth+1  occupancy, 0..DEPTH.
- almost_full  out  1  occupancy ≥ AfullThr.
- almost_empty  out  1  occupancy ≤ AemptyThr.
- overflow, underflow  out  1  sticky error flags (FIFO_FWFT_ERR_FLAGS_EN only).
- clr_err  in  1  clears sticky flags (FIFO_FWFT_ERR_FLAGS_EN only).

## Operation
- Accepted write: w_op = w_en & w_ready. Accepted pop: r_op = r_en & r_ready.
- Pointers are AddrBitWidth+1 bits wide. Full means the low bits are equal and the MSB differs. Addresses wrap naturally modulo DEPTH.
- fifo_size includes entries in RAM plus the output register. At each edge it changes by +1 on w_op only, −1 on r_op only, and is unchanged when both or neither occur.
- FWFT: whenever any entry exists, the oldest is prefetched into the output register. dataR is stable while r_ready=1 and r_en=0.
- Full: w_ready=0, and w_en is ignored even if r_op occurs in the same cycle. There is no full-state pass-through.
- Empty: r_ready=0, r_en is ignored, and dataR holds its last value.
- flush (rst inactive): at the edge, pointers, fifo_size and r_ready are cleared and w_ready=1. Flush has priority over w_en and r_en in that cycle.
- Reset (async, any time, including mid-transfer): pointers=0, fifo_size=0, r_ready=0, w_ready=0, almost_full=0, almost_empty=1, dataR=0, error flags=0. w_ready rises at the first edge after rst deasserts.
- All status outputs are registered and reflect state after the current edge.

## Timing
- Push into an empty FIFO at edge N gives r_ready=1 with that data on dataR after edge N+1, i.e. 2-cycle write-to-read latency. In cycle N+1, fifo_size=1 while r_ready=0.
- Back-to-back pops at 1 per cycle are sustained while fifo_size ≥ 2. The next entry appears on dataR directly after the popping edge.
- Simultaneous push and pop at 1 per cycle are sustained indefinitely at any occupancy between 1 and DEPTH−1.
- w_ready drops in the cycle after the edge that makes fifo_size=DEPTH, and rises the cycle after the next r_op.

## Configuration
- FIFO_FWFT_ERR_FLAGS_EN defined:
  - Ports overflow, underflow and clr_err exist.
  - overflow is set at an edge with w_en & !w_ready; underflow is set at an edge with r_en & !r_ready.
  - Both hold until clr_err, which has priority over setting in the same cycle, or until rst.
  - flush does not clear them.
- FIFO_FWFT_ERR_FLAGS_EN undefined: the ports are absent and invalid requests are silently dropped.

## Structure
- Package fifo_pkg: depth-from-AddrBitWidth constant function and the pointer full/empty compare function, shared with future FIFO variants.
- Sub-module fifo_ram_2p: simple dual-port RAM with one write port and a registered read port, DataWidth × DEPTH. fifo_fwft contains the pointers, prefetch/output register control, counters and flags.

## Test plan
- Reset, then push 0xA5 at edge 1: fifo_size=1 after edge 1; r_ready=1 and dataR=0xA5 after edge 2; almost_empty=1.
- AddrBitWidth=4: 16 pushes of 0..15 give fifo_size=16, w_ready=0 and almost_full=1. A 17th w_en is dropped (overflow=1 with macro). Draining returns 0..15 in order.
- Continuous simultaneous push/pop at occupancy 5 for 40 cycles: fifo_size stays 5, data stays in order, and pointers wrap twice.
- flush asserted with w_en=1 at occupancy 7: the next cycle shows fifo_size=0, r_ready=0, w_ready=1, and the write is not stored.
- rst asserted asynchronously mid-burst between edges: outputs go to reset values immediately. After release, w_ready=1 at the first edge and there is no stale data on a later r_ready.
- Pop on empty with macro defined: underflow=1. clr_err and r_en on empty in the same cycle leave underflow=0.
